// File: rtl/mem_bus_router.sv
// mem_bus_router: routes single-outstanding MEM-stage loads/stores to N_TGT targets via an address select field.
// Define MEM_BUS_ROUTER_UNMAPPED_ERR_EN to answer unmapped selectors with an error instead of routing to DEFAULT_TGT.
module mem_bus_router #(
  parameter int N_TGT       = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int SEL_LSB     = 28,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_TGT = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [DW-1:0]       i_wdata,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_err,
  output logic [N_TGT-1:0]    o_tgt_req,
  output logic                o_tgt_we,
  output logic [AW-1:0]       o_tgt_addr,
  output logic [DW-1:0]       o_tgt_wdata,
  input  logic [N_TGT-1:0]    i_tgt_ack,
  input  logic [N_TGT*DW-1:0] i_tgt_rdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t r_state, w_next;
  logic [SEL_W-1:0] w_sel, w_tgt, r_tgt;
  logic w_mapped, w_skip, w_ack, w_to;
  logic [CW-1:0] r_cnt;
  logic [N_TGT-1:0] w_onehot;
  logic [DW-1:0] w_rdata;
  assign w_sel = i_addr[SEL_LSB +: SEL_W];
  assign w_mapped = {1'b0, w_sel} < (SEL_W + 1)'(N_TGT);
  assign w_tgt = w_mapped ? w_sel : SEL_W'(DEFAULT_TGT);
`ifdef MEM_BUS_ROUTER_UNMAPPED_ERR_EN
  assign w_skip = !w_mapped;
`else
  assign w_skip = 1'b0;
`endif
  assign w_onehot = N_TGT'(1) << r_tgt;
  assign w_ack = |(i_tgt_ack & w_onehot);
  // Ack is checked before timeout in the datapath, so a same-cycle ack wins.
  assign w_to = TIMEOUT != 0 && r_cnt == TO_LAST;
  always_comb begin
    w_rdata = '0;
    for (int t = 0; t < N_TGT; t++)
      if (r_tgt == SEL_W'(t)) w_rdata = i_tgt_rdata[t*DW +: DW];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_req ? (w_skip ? RESP : ISSUE) : IDLE;
      ISSUE:   w_next = (w_ack || w_to) ? RESP : ISSUE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_ready = r_state == IDLE && !i_reset;
    o_valid = r_state == RESP;
    o_tgt_req = r_state == ISSUE ? w_onehot : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgt       <= '0;
      r_cnt       <= '0;
      o_tgt_we    <= 1'b0;
      o_tgt_addr  <= '0;
      o_tgt_wdata <= '0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
    end else begin
      if (r_state == IDLE && i_req) begin
        r_tgt       <= w_tgt;
        o_tgt_we    <= i_we;
        o_tgt_addr  <= i_addr;
        o_tgt_wdata <= i_wdata;
        if (w_skip) begin
          o_rdata <= '0;
          o_err   <= 1'b1;
        end
      end
      if (r_state == ISSUE) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_ack) begin
          o_rdata <= o_tgt_we ? '0 : w_rdata;
          o_err   <= 1'b0;
        end else if (w_to) begin
          o_rdata <= '0;
          o_err   <= 1'b1;
        end
      end
      if (r_state == RESP) r_cnt <= '0;
    end
  end
endmodule
